// File: rtl/spi_peripheral_regs.sv
// SPI peripheral with a byte-wide register file, 1/2/4 data lanes, auto-incrementing
// wrapping address, configurable read turnaround and a combinational debug read port.
module spi_peripheral_regs #(
  parameter int LANES      = 4,
  parameter int ADDR_BITS  = 4,
  parameter int READ_DUMMY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_cs_n,
  input  logic [LANES-1:0]     spi_d_in,
  output logic [LANES-1:0]     spi_d_out,
  output logic [LANES-1:0]     spi_d_oe,
  output logic                 wr_strobe,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [7:0]           wr_data,
  input  logic [ADDR_BITS-1:0] dbg_addr,
  output logic [7:0]           dbg_data
);

  localparam int          BPC        = 8 / LANES;
  localparam logic [2:0]  BPC_LAST   = 3'(BPC - 1);
  localparam logic [3:0]  DUMMY_LAST = 4'(READ_DUMMY - 1);
  localparam int unsigned DEPTH      = 1 << ADDR_BITS;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_DUMMY = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;

  logic [7:0]           regs [DEPTH];
  logic [2:0]           state;
  logic [2:0]           bit_cnt;
  logic [3:0]           dummy_cnt;
  logic [7:0]           sr;
  logic [ADDR_BITS-1:0] addr;
  logic [ADDR_BITS-1:0] addr_inc;
  logic [7:0]           in_byte;

  // One shift register serves both directions: inbound groups enter at the bottom,
  // outbound groups leave from the top.
  assign in_byte   = {sr[7-LANES:0], spi_d_in};
  assign addr_inc  = addr + ADDR_BITS'(1);
  assign spi_d_out = sr[7 -: LANES];
  assign spi_d_oe  = (state == S_READ) ? '1 : '0;
  assign dbg_data  = regs[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      state     <= S_IDLE;
      bit_cnt   <= '0;
      dummy_cnt <= '0;
      sr        <= '0;
      addr      <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (spi_cs_n) begin
        // Deselect wins over everything: partial bytes are dropped, nothing commits.
        state     <= S_IDLE;
        bit_cnt   <= '0;
        dummy_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            sr      <= in_byte;
            bit_cnt <= 3'd1;
            state   <= S_CMD;
          end
          S_CMD: begin
            sr <= in_byte;
            if (bit_cnt == BPC_LAST) begin
              bit_cnt <= '0;
              addr    <= in_byte[ADDR_BITS-1:0];
              if (in_byte[7]) begin
                if (READ_DUMMY == 0) begin
                  state <= S_READ;
                  sr    <= regs[in_byte[ADDR_BITS-1:0]];
                end else begin
                  state     <= S_DUMMY;
                  dummy_cnt <= '0;
                end
              end else begin
                state <= S_WRITE;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          S_DUMMY: begin
            if (dummy_cnt == DUMMY_LAST) begin
              state <= S_READ;
              sr    <= regs[addr];
            end else begin
              dummy_cnt <= dummy_cnt + 4'd1;
            end
          end
          S_WRITE: begin
            sr <= in_byte;
            if (bit_cnt == BPC_LAST) begin
              regs[addr] <= in_byte;
              wr_strobe  <= 1'b1;
              wr_addr    <= addr;
              wr_data    <= in_byte;
              addr       <= addr_inc;
              bit_cnt    <= '0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          S_READ: begin
            if (bit_cnt == BPC_LAST) begin
              sr      <= regs[addr_inc];
              addr    <= addr_inc;
              bit_cnt <= '0;
            end else begin
              sr      <= sr << LANES;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
